// File: rtl/usb_wb_initiator.sv
// Wishbone B4 classic initiator for the USB device core debug port.
// Turns a command/write-data stream into single or incrementing-burst bus cycles and returns one response per beat.
module usb_wb_initiator #(
  parameter int TIMEOUT = 256
) (
  input  logic        clk48,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_we,
  input  logic [29:0] cmd_adr,
  input  logic [3:0]  cmd_sel,
  input  logic [7:0]  cmd_len,
  input  logic        wd_valid,
  output logic        wd_ready,
  input  logic [31:0] wd_dat,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_dat,
  output logic        rsp_err,
  output logic        rsp_timeout,
  output logic        rsp_last,
  output logic [29:0] wishbone_adr,
  output logic [31:0] wishbone_dat_w,
  output logic [3:0]  wishbone_sel,
  output logic        wishbone_cyc,
  output logic        wishbone_stb,
  output logic        wishbone_we,
  output logic [2:0]  wishbone_cti,
  output logic [1:0]  wishbone_bte,
  input  logic [31:0] wishbone_dat_r,
  input  logic        wishbone_ack,
  input  logic        wishbone_err
);

  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    IDLE,
    BEAT,
    DRAIN
  } state_t;

  state_t          r_state;
  logic [7:0]      r_len;
  logic [7:0]      r_remain;
  logic [TW-1:0]   r_tcnt;

  logic w_raise;
  logic w_ack;
  logic w_err;
  logic w_tmo;
  logic w_term;
  logic w_final;
  logic w_abort;

  // A new beat starts only once the previous response has left the single response register.
  assign w_raise = (r_state == BEAT) && !wishbone_stb && !rsp_valid &&
                   (!wishbone_we || wd_valid);

  assign w_err   = wishbone_cyc && wishbone_stb && wishbone_err;
  assign w_ack   = wishbone_cyc && wishbone_stb && wishbone_ack && !wishbone_err;
  assign w_tmo   = wishbone_cyc && wishbone_stb && !wishbone_ack && !wishbone_err &&
                   (r_tcnt == TW'(TIMEOUT - 1));
  assign w_term  = w_ack || w_err || w_tmo;
  assign w_final = (r_remain == 8'd0);
  assign w_abort = w_err || w_tmo;

  assign cmd_ready    = (r_state == IDLE) && !reset;
  assign wishbone_bte = 2'b00;

  always_ff @(posedge clk48 or posedge reset) begin
    if (reset) begin
      r_state        <= IDLE;
      r_len          <= 8'd0;
      r_remain       <= 8'd0;
      r_tcnt         <= '0;
      wishbone_adr   <= 30'd0;
      wishbone_dat_w <= 32'd0;
      wishbone_sel   <= 4'd0;
      wishbone_cyc   <= 1'b0;
      wishbone_stb   <= 1'b0;
      wishbone_we    <= 1'b0;
      wishbone_cti   <= 3'b000;
      wd_ready       <= 1'b0;
      rsp_valid      <= 1'b0;
      rsp_dat        <= 32'd0;
      rsp_err        <= 1'b0;
      rsp_timeout    <= 1'b0;
      rsp_last       <= 1'b0;
    end else begin
      wd_ready <= 1'b0;
      if (rsp_valid && rsp_ready) begin
        rsp_valid <= 1'b0;
      end

      case (r_state)
        IDLE: begin
          if (cmd_valid) begin
            wishbone_adr <= cmd_adr;
            wishbone_sel <= cmd_sel;
            wishbone_we  <= cmd_we;
            wishbone_cyc <= 1'b1;
            r_len        <= cmd_len;
            r_remain     <= cmd_len;
            r_state      <= BEAT;
          end
        end

        BEAT: begin
          if (w_raise) begin
            wishbone_stb <= 1'b1;
            r_tcnt       <= '0;
            if (r_len == 8'd0) begin
              wishbone_cti <= 3'b000;
            end else if (r_remain == 8'd0) begin
              wishbone_cti <= 3'b111;
            end else begin
              wishbone_cti <= 3'b010;
            end
            if (wishbone_we) begin
              wishbone_dat_w <= wd_dat;
              wd_ready       <= 1'b1;
            end
          end else if (wishbone_stb) begin
            if (w_term) begin
              wishbone_stb <= 1'b0;
              rsp_valid    <= 1'b1;
              rsp_dat      <= (w_ack && !wishbone_we) ? wishbone_dat_r : 32'd0;
              rsp_err      <= w_err;
              rsp_timeout  <= w_tmo;
              rsp_last     <= w_final || w_abort;
              if (w_ack) begin
                wishbone_adr <= wishbone_adr + 30'd1;
              end
              // An aborted write still owes the source its un-issued beats, so swallow them first.
              if (w_final || w_abort) begin
                wishbone_cyc <= 1'b0;
                if (w_abort && wishbone_we && !w_final) begin
                  r_state  <= DRAIN;
                  wd_ready <= 1'b1;
                end else begin
                  r_state <= IDLE;
                end
              end else begin
                r_remain <= r_remain - 8'd1;
              end
            end else begin
              r_tcnt <= r_tcnt + 1'b1;
            end
          end
        end

        DRAIN: begin
          wd_ready <= 1'b1;
          if (wd_valid && wd_ready) begin
            if (r_remain == 8'd1) begin
              wd_ready <= 1'b0;
              r_state  <= IDLE;
            end else begin
              r_remain <= r_remain - 8'd1;
            end
          end
        end

        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_usb_wb_initiator.sv
// Directed bench for usb_wb_initiator: a wait-state slave, a write-data source and bus/response monitors.
module tb_usb_wb_initiator;

  logic        clk48 = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_we = 1'b0;
  logic [29:0] cmd_adr = '0;
  logic [3:0]  cmd_sel = '0;
  logic [7:0]  cmd_len = '0;
  logic        wd_valid = 1'b0;
  logic        wd_ready;
  logic [31:0] wd_dat = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_dat;
  logic        rsp_err;
  logic        rsp_timeout;
  logic        rsp_last;
  logic [29:0] wishbone_adr;
  logic [31:0] wishbone_dat_w;
  logic [3:0]  wishbone_sel;
  logic        wishbone_cyc;
  logic        wishbone_stb;
  logic        wishbone_we;
  logic [2:0]  wishbone_cti;
  logic [1:0]  wishbone_bte;
  logic [31:0] wishbone_dat_r = '0;
  logic        wishbone_ack = 1'b0;
  logic        wishbone_err = 1'b0;

  int nChecks = 0;
  int nFails  = 0;

  usb_wb_initiator #(.TIMEOUT(256)) dut (
    .clk48(clk48), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_adr(cmd_adr), .cmd_sel(cmd_sel), .cmd_len(cmd_len),
    .wd_valid(wd_valid), .wd_ready(wd_ready), .wd_dat(wd_dat),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_dat(rsp_dat),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout), .rsp_last(rsp_last),
    .wishbone_adr(wishbone_adr), .wishbone_dat_w(wishbone_dat_w),
    .wishbone_sel(wishbone_sel), .wishbone_cyc(wishbone_cyc),
    .wishbone_stb(wishbone_stb), .wishbone_we(wishbone_we),
    .wishbone_cti(wishbone_cti), .wishbone_bte(wishbone_bte),
    .wishbone_dat_r(wishbone_dat_r), .wishbone_ack(wishbone_ack),
    .wishbone_err(wishbone_err)
  );

  always #5 clk48 = ~clk48;

  function automatic logic [31:0] rdat(input logic [29:0] a);
    return {2'b00, a} ^ 32'hA5A5_5A5A;
  endfunction

  typedef struct {
    logic [29:0] adr;
    logic [2:0]  cti;
    logic        we;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic        err;
  } beat_t;

  typedef struct {
    logic [31:0] dat;
    logic        err;
    logic        tmo;
    logic        last;
  } rsp_t;

  beat_t busQ[$];
  rsp_t  rspQ[$];
  int    stbCount = 0;

  // Bus and response monitors sample mid-cycle; a terminating beat or consumed response is logged once.
  always @(negedge clk48) begin
    beat_t b;
    rsp_t  r;
    if (!reset) begin
      if (wishbone_cyc && wishbone_stb) stbCount++;
      if (wishbone_cyc && wishbone_stb && (wishbone_ack || wishbone_err)) begin
        b.adr = wishbone_adr;
        b.cti = wishbone_cti;
        b.we  = wishbone_we;
        b.dat = wishbone_dat_w;
        b.sel = wishbone_sel;
        b.err = wishbone_err;
        busQ.push_back(b);
      end
      if (rsp_valid && rsp_ready) begin
        r.dat  = rsp_dat;
        r.err  = rsp_err;
        r.tmo  = rsp_timeout;
        r.last = rsp_last;
        rspQ.push_back(r);
      end
    end
  end

  int waitStates = 0;
  int errAt      = -1;
  bit noAck      = 1'b0;
  int slaveBeats = 0;
  int slaveCnt   = 0;

  // Slave: acks after waitStates idle strobe cycles, answers err on the selected beat, or stays silent.
  always @(posedge clk48) begin
    #1;
    if (reset) begin
      wishbone_ack = 1'b0;
      wishbone_err = 1'b0;
      slaveCnt     = 0;
    end else if (wishbone_ack || wishbone_err) begin
      wishbone_ack = 1'b0;
      wishbone_err = 1'b0;
    end else if (wishbone_cyc && wishbone_stb && !noAck) begin
      if (slaveCnt >= waitStates) begin
        slaveCnt = 0;
        if (slaveBeats == errAt) begin
          wishbone_err = 1'b1;
        end else begin
          wishbone_ack   = 1'b1;
          wishbone_dat_r = rdat(wishbone_adr);
        end
        slaveBeats++;
      end else begin
        slaveCnt++;
      end
    end else begin
      slaveCnt = 0;
    end
  end

  logic [31:0] wdMem[16];
  int wdWr = 0;
  int wdRd = 0;
  int wdHs = 0;
  bit wdHsNow;

  // Write-data source: a beat is retired on the edge where wd_valid and wd_ready are both high.
  always @(posedge clk48) begin
    wdHsNow = wd_valid && wd_ready;
    #1;
    if (wdHsNow) begin
      wdRd++;
      wdHs++;
    end
    wd_valid = (wdRd < wdWr);
    wd_dat   = wd_valid ? wdMem[wdRd % 16] : 32'd0;
  end

  task automatic sendCmd(input logic we, input logic [29:0] adr, input logic [3:0] sel,
                         input logic [7:0] len, output bit ok);
    @(posedge clk48);
    #2;
    cmd_valid = 1'b1;
    cmd_we    = we;
    cmd_adr   = adr;
    cmd_sel   = sel;
    cmd_len   = len;
    ok        = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk48);
      if (cmd_ready) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk48);
    #2;
    cmd_valid = 1'b0;
  endtask

  task automatic waitRsp(input int total, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk48);
      #1;
      if (rspQ.size() >= total) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk48);
    nChecks++;
    if ({wishbone_cyc, wishbone_stb, wishbone_we, wishbone_adr, wishbone_dat_w, wishbone_sel,
         wishbone_cti, wishbone_bte, cmd_ready, wd_ready, rsp_valid, rsp_dat, rsp_err,
         rsp_timeout, rsp_last} !== '0) begin
      nFails++;
      $display("[TB] FAIL reset_outputs: got cyc=%b stb=%b adr=%h cti=%b cmd_ready=%b rsp_valid=%b, expected all zero",
               wishbone_cyc, wishbone_stb, wishbone_adr, wishbone_cti, cmd_ready, rsp_valid);
    end
    @(posedge clk48);
    #2;
    reset = 1'b0;
    @(negedge clk48);
    nChecks++;
    if (cmd_ready !== 1'b1) begin
      nFails++;
      $display("[TB] FAIL reset_cmd_ready: got %b expected 1", cmd_ready);
    end
  endtask

  task automatic test_single_write();
    int b0 = busQ.size();
    int r0 = rspQ.size();
    int s0 = stbCount;
    int h0 = wdHs;
    bit ok;
    waitStates = 3;
    wdMem[wdWr % 16] = 32'hDEADBEEF;
    wdWr++;
    sendCmd(1'b1, 30'h10, 4'hF, 8'd0, ok);
    nChecks++;
    if (!ok) begin
      nFails++;
      $display("[TB] FAIL sw_accept: got no accept expected accept");
    end
    waitRsp(r0 + 1, 100, ok);
    repeat (3) @(negedge clk48);
    nChecks++;
    if (busQ.size() - b0 !== 1) begin
      nFails++;
      $display("[TB] FAIL sw_beats: got %0d expected 1", busQ.size() - b0);
    end else begin
      nChecks++;
      if ({busQ[b0].adr, busQ[b0].cti, busQ[b0].we, busQ[b0].dat, busQ[b0].sel} !==
          {30'h10, 3'b000, 1'b1, 32'hDEADBEEF, 4'hF}) begin
        nFails++;
        $display("[TB] FAIL sw_beat: got adr=%h cti=%b we=%b dat=%h sel=%h expected 10/000/1/deadbeef/f",
                 busQ[b0].adr, busQ[b0].cti, busQ[b0].we, busQ[b0].dat, busQ[b0].sel);
      end
    end
    nChecks++;
    if (stbCount - s0 !== 4) begin
      nFails++;
      $display("[TB] FAIL sw_stb_cycles: got %0d expected 4", stbCount - s0);
    end
    nChecks++;
    if (rspQ.size() - r0 !== 1) begin
      nFails++;
      $display("[TB] FAIL sw_rsp_count: got %0d expected 1", rspQ.size() - r0);
    end else begin
      nChecks++;
      if ({rspQ[r0].last, rspQ[r0].err, rspQ[r0].tmo, rspQ[r0].dat} !== {3'b100, 32'd0}) begin
        nFails++;
        $display("[TB] FAIL sw_rsp: got last=%b err=%b tmo=%b dat=%h expected 1/0/0/0",
                 rspQ[r0].last, rspQ[r0].err, rspQ[r0].tmo, rspQ[r0].dat);
      end
    end
    nChecks++;
    if (wdHs - h0 !== 1) begin
      nFails++;
      $display("[TB] FAIL sw_wd_beats: got %0d expected 1", wdHs - h0);
    end
    nChecks++;
    if ({wishbone_cyc, cmd_ready} !== 2'b01) begin
      nFails++;
      $display("[TB] FAIL sw_idle: got cyc=%b cmd_ready=%b expected 0/1", wishbone_cyc, cmd_ready);
    end
  endtask

  task automatic test_burst_read_wrap();
    logic [29:0] expA[4];
    logic [2:0]  expC[4];
    int b0 = busQ.size();
    int r0 = rspQ.size();
    bit ok;
    expA = '{30'h3FFFFFFE, 30'h3FFFFFFF, 30'h00000000, 30'h00000001};
    expC = '{3'b010, 3'b010, 3'b010, 3'b111};
    waitStates = 0;
    sendCmd(1'b0, 30'h3FFFFFFE, 4'hF, 8'd3, ok);
    waitRsp(r0 + 4, 200, ok);
    repeat (3) @(negedge clk48);
    nChecks++;
    if (busQ.size() - b0 !== 4 || rspQ.size() - r0 !== 4) begin
      nFails++;
      $display("[TB] FAIL br_counts: got beats=%0d rsps=%0d expected 4/4", busQ.size() - b0, rspQ.size() - r0);
    end else begin
      for (int i = 0; i < 4; i++) begin
        nChecks++;
        if ({busQ[b0 + i].adr, busQ[b0 + i].cti, busQ[b0 + i].we} !== {expA[i], expC[i], 1'b0}) begin
          nFails++;
          $display("[TB] FAIL br_beat%0d: got adr=%h cti=%b we=%b expected adr=%h cti=%b we=0",
                   i, busQ[b0 + i].adr, busQ[b0 + i].cti, busQ[b0 + i].we, expA[i], expC[i]);
        end
        nChecks++;
        if ({rspQ[r0 + i].dat, rspQ[r0 + i].last, rspQ[r0 + i].err} !== {rdat(expA[i]), i == 3, 1'b0}) begin
          nFails++;
          $display("[TB] FAIL br_rsp%0d: got dat=%h last=%b err=%b expected dat=%h last=%b err=0",
                   i, rspQ[r0 + i].dat, rspQ[r0 + i].last, rspQ[r0 + i].err, rdat(expA[i]), i == 3);
        end
      end
    end
  endtask

  task automatic test_rsp_backpressure();
    int r0 = rspQ.size();
    bit ok;
    bit seen = 1'b0;
    waitStates = 1;
    @(posedge clk48);
    #2;
    rsp_ready = 1'b0;
    sendCmd(1'b0, 30'h100, 4'hF, 8'd3, ok);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk48);
      if (rsp_valid) begin
        seen = 1'b1;
        break;
      end
    end
    nChecks++;
    if (!seen) begin
      nFails++;
      $display("[TB] FAIL bp_first_rsp: got no response within 100 cycles expected one");
    end
    for (int i = 0; i < 10; i++) begin
      nChecks++;
      if ({wishbone_stb, wishbone_cyc, rsp_valid, rsp_dat} !== {3'b011, rdat(30'h100)}) begin
        nFails++;
        $display("[TB] FAIL bp_hold%0d: got stb=%b cyc=%b rsp_valid=%b dat=%h expected 0/1/1/%h",
                 i, wishbone_stb, wishbone_cyc, rsp_valid, rsp_dat, rdat(30'h100));
      end
      @(negedge clk48);
    end
    @(posedge clk48);
    #2;
    rsp_ready = 1'b1;
    waitRsp(r0 + 4, 200, ok);
    nChecks++;
    if (rspQ.size() - r0 !== 4) begin
      nFails++;
      $display("[TB] FAIL bp_rsp_count: got %0d expected 4", rspQ.size() - r0);
    end else begin
      for (int i = 0; i < 4; i++) begin
        nChecks++;
        if ({rspQ[r0 + i].dat, rspQ[r0 + i].last} !== {rdat(30'h100 + 30'(i)), i == 3}) begin
          nFails++;
          $display("[TB] FAIL bp_rsp%0d: got dat=%h last=%b expected dat=%h last=%b",
                   i, rspQ[r0 + i].dat, rspQ[r0 + i].last, rdat(30'h100 + 30'(i)), i == 3);
        end
      end
    end
  endtask

  task automatic test_write_err_drain();
    int b0 = busQ.size();
    int r0 = rspQ.size();
    int h0 = wdHs;
    bit ok;
    bit drained = 1'b0;
    waitStates = 0;
    for (int i = 0; i < 4; i++) begin
      wdMem[wdWr % 16] = 32'h1111_0000 + 32'(i);
      wdWr++;
    end
    errAt = slaveBeats + 1;
    sendCmd(1'b1, 30'h20, 4'h3, 8'd3, ok);
    waitRsp(r0 + 2, 200, ok);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk48);
      if (cmd_ready && wdRd == wdWr) begin
        drained = 1'b1;
        break;
      end
    end
    repeat (5) @(negedge clk48);
    errAt = -1;
    nChecks++;
    if (!drained || wdHs - h0 !== 4) begin
      nFails++;
      $display("[TB] FAIL we_drain: got drained=%b wd_beats=%0d expected 1/4", drained, wdHs - h0);
    end
    nChecks++;
    if (busQ.size() - b0 !== 2) begin
      nFails++;
      $display("[TB] FAIL we_beats: got %0d expected 2", busQ.size() - b0);
    end else begin
      nChecks++;
      if ({busQ[b0].adr, busQ[b0].dat, busQ[b0].err, busQ[b0].cti, busQ[b0].sel} !==
          {30'h20, 32'h1111_0000, 1'b0, 3'b010, 4'h3}) begin
        nFails++;
        $display("[TB] FAIL we_beat0: got adr=%h dat=%h err=%b cti=%b sel=%h expected 20/11110000/0/010/3",
                 busQ[b0].adr, busQ[b0].dat, busQ[b0].err, busQ[b0].cti, busQ[b0].sel);
      end
      nChecks++;
      if ({busQ[b0 + 1].adr, busQ[b0 + 1].dat, busQ[b0 + 1].err} !== {30'h21, 32'h1111_0001, 1'b1}) begin
        nFails++;
        $display("[TB] FAIL we_beat1: got adr=%h dat=%h err=%b expected 21/11110001/1",
                 busQ[b0 + 1].adr, busQ[b0 + 1].dat, busQ[b0 + 1].err);
      end
    end
    nChecks++;
    if (rspQ.size() - r0 !== 2) begin
      nFails++;
      $display("[TB] FAIL we_rsp_count: got %0d expected 2", rspQ.size() - r0);
    end else begin
      nChecks++;
      if ({rspQ[r0].err, rspQ[r0].last, rspQ[r0 + 1].err, rspQ[r0 + 1].last, rspQ[r0 + 1].tmo} !== 5'b00110) begin
        nFails++;
        $display("[TB] FAIL we_rsp_flags: got err0=%b last0=%b err1=%b last1=%b tmo1=%b expected 0/0/1/1/0",
                 rspQ[r0].err, rspQ[r0].last, rspQ[r0 + 1].err, rspQ[r0 + 1].last, rspQ[r0 + 1].tmo);
      end
    end
    nChecks++;
    if ({cmd_ready, wishbone_cyc, wd_ready} !== 3'b100) begin
      nFails++;
      $display("[TB] FAIL we_idle: got cmd_ready=%b cyc=%b wd_ready=%b expected 1/0/0", cmd_ready, wishbone_cyc, wd_ready);
    end
  endtask

  task automatic test_timeout();
    int b0 = busQ.size();
    int r0 = rspQ.size();
    int s0 = stbCount;
    bit ok;
    noAck = 1'b1;
    sendCmd(1'b0, 30'h40, 4'hF, 8'd0, ok);
    waitRsp(r0 + 1, 400, ok);
    repeat (3) @(negedge clk48);
    noAck = 1'b0;
    nChecks++;
    if (stbCount - s0 !== 256) begin
      nFails++;
      $display("[TB] FAIL to_stb_cycles: got %0d expected 256", stbCount - s0);
    end
    nChecks++;
    if (rspQ.size() - r0 !== 1) begin
      nFails++;
      $display("[TB] FAIL to_rsp_count: got %0d expected 1", rspQ.size() - r0);
    end else begin
      nChecks++;
      if ({rspQ[r0].tmo, rspQ[r0].last, rspQ[r0].err} !== 3'b110) begin
        nFails++;
        $display("[TB] FAIL to_rsp_flags: got tmo=%b last=%b err=%b expected 1/1/0",
                 rspQ[r0].tmo, rspQ[r0].last, rspQ[r0].err);
      end
    end
    nChecks++;
    if (busQ.size() - b0 !== 0 || wishbone_cyc !== 1'b0) begin
      nFails++;
      $display("[TB] FAIL to_bus_idle: got terminations=%0d cyc=%b expected 0/0", busQ.size() - b0, wishbone_cyc);
    end
  endtask

  task automatic test_reset_mid_burst();
    int r0 = rspQ.size();
    bit ok;
    bit hit = 1'b0;
    waitStates = 2;
    sendCmd(1'b0, 30'h200, 4'hF, 8'd7, ok);
    waitRsp(r0 + 2, 200, ok);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk48);
      if (wishbone_stb) begin
        hit = 1'b1;
        break;
      end
    end
    reset = 1'b1;
    #1;
    nChecks++;
    if (!hit || {wishbone_cyc, wishbone_stb, rsp_valid, cmd_ready} !== 4'b0000) begin
      nFails++;
      $display("[TB] FAIL rst_stb_phase: got hit=%b cyc=%b stb=%b rsp_valid=%b cmd_ready=%b expected 1/0/0/0/0",
               hit, wishbone_cyc, wishbone_stb, rsp_valid, cmd_ready);
    end
    repeat (2) @(posedge clk48);
    #2;
    reset = 1'b0;
    @(negedge clk48);
    nChecks++;
    if ({cmd_ready, wishbone_cyc} !== 2'b10) begin
      nFails++;
      $display("[TB] FAIL rst_recover1: got cmd_ready=%b cyc=%b expected 1/0", cmd_ready, wishbone_cyc);
    end

    // Second pass: reset lands while a response is still waiting to be consumed.
    hit = 1'b0;
    @(posedge clk48);
    #2;
    rsp_ready = 1'b0;
    sendCmd(1'b0, 30'h300, 4'hF, 8'd3, ok);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk48);
      if (rsp_valid) begin
        hit = 1'b1;
        break;
      end
    end
    reset = 1'b1;
    #1;
    nChecks++;
    if (!hit || {wishbone_cyc, wishbone_stb, rsp_valid} !== 3'b000) begin
      nFails++;
      $display("[TB] FAIL rst_rsp_phase: got hit=%b cyc=%b stb=%b rsp_valid=%b expected 1/0/0/0",
               hit, wishbone_cyc, wishbone_stb, rsp_valid);
    end
    repeat (2) @(posedge clk48);
    #2;
    reset = 1'b0;
    rsp_ready = 1'b1;
    repeat (2) @(negedge clk48);
    nChecks++;
    if ({cmd_ready, wishbone_cyc, rsp_valid} !== 3'b100) begin
      nFails++;
      $display("[TB] FAIL rst_recover2: got cmd_ready=%b cyc=%b rsp_valid=%b expected 1/0/0",
               cmd_ready, wishbone_cyc, rsp_valid);
    end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_burst_read_wrap();
    test_rsp_backpressure();
    test_write_err_drain();
    test_timeout();
    test_reset_mid_burst();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
